// File: rtl/otter_pkg.sv
// Shared OTTER definitions: base opcodes, the NOP encoding, register-use helpers
// and the per-stage {ir, pc, v} record used by the instruction-register pipeline.
package otter_pkg;

    localparam int OTTER_XLEN = 32;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [OTTER_XLEN-1:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [OTTER_XLEN-1:0] ir;
        logic [OTTER_XLEN-1:0] pc;
        logic                  v;
    } stage_t;

    localparam stage_t BUBBLE = '{ir: NOP, pc: '0, v: 1'b0};

    // SYSTEM reads rs1 only for the register forms of CSR access (func3[2]=0).
    function automatic logic uses_rs1(input logic [OTTER_XLEN-1:0] ir);
        logic r;
        r = 1'b0;
        case (ir[6:0])
            JALR, BRANCH, LOAD, STORE, OP_IMM, OP: r = 1'b1;
            SYSTEM:                                r = ~ir[14];
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input logic [OTTER_XLEN-1:0] ir);
        logic r;
        r = 1'b0;
        case (ir[6:0])
            BRANCH, STORE, OP: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    // Destination register of a load, or x0 when the word is not a load.
    function automatic logic [4:0] load_dest(input logic [OTTER_XLEN-1:0] ir);
        return (ir[6:0] == LOAD) ? ir[11:7] : 5'd0;
    endfunction

endpackage

// File: rtl/otter_hazard_detect.sv
// Combinational load-use detector: flags a valid load in EXE whose non-zero rd
// is read by the valid instruction currently sitting in DEC.
module otter_hazard_detect
    import otter_pkg::*;
(
    input  logic [OTTER_XLEN-1:0] DEC_IR,
    input  logic                  DEC_V,
    input  logic [OTTER_XLEN-1:0] EXE_IR,
    input  logic                  EXE_V,
    output logic                  hazard
);

    logic [4:0] exe_rd;
    logic       rs1_hit;
    logic       rs2_hit;

    assign exe_rd  = load_dest(EXE_IR);
    assign rs1_hit = uses_rs1(DEC_IR) && (DEC_IR[19:15] == exe_rd);
    assign rs2_hit = uses_rs2(DEC_IR) && (DEC_IR[24:20] == exe_rd);
    assign hazard  = EXE_V && (exe_rd != 5'd0) && DEC_V && (rs1_hit || rs2_hit);

endmodule

// File: rtl/otter_ir_pipeline.sv
// DEC/EXE/MEM/WB instruction and PC registers for the OTTER core, with flush on
// CLEAR, one-cycle load-use stall, MEM_WAIT freeze and saturating event counters.
module otter_ir_pipeline
    import otter_pkg::*;
#(
    parameter int XLEN  = OTTER_XLEN,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XLEN-1:0]  IF_IR,
    input  logic [XLEN-1:0]  IF_PC,
    input  logic             IF_VALID,
    input  logic             CLEAR,
    input  logic             MEM_WAIT,
    output logic [XLEN-1:0]  DEC_IR,
    output logic [XLEN-1:0]  EXE_IR,
    output logic [XLEN-1:0]  MEM_IR,
    output logic [XLEN-1:0]  WB_IR,
    output logic [XLEN-1:0]  DEC_PC,
    output logic [XLEN-1:0]  EXE_PC,
    output logic [XLEN-1:0]  MEM_PC,
    output logic [XLEN-1:0]  WB_PC,
    output logic             DEC_V,
    output logic             EXE_V,
    output logic             MEM_V,
    output logic             WB_V,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t dec_q, exe_q, mem_q, wb_q;
    stage_t if_stage;
    logic   hazard;

    otter_hazard_detect u_hazard (
        .DEC_IR (dec_q.ir),
        .DEC_V  (dec_q.v),
        .EXE_IR (exe_q.ir),
        .EXE_V  (exe_q.v),
        .hazard (hazard)
    );

    assign if_stage = IF_VALID ? '{ir: IF_IR, pc: IF_PC, v: 1'b1} : BUBBLE;
    assign STALL    = hazard & ~CLEAR & ~MEM_WAIT;

    // Priority: reset, memory freeze, flush, load-use stall, then normal advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dec_q     <= BUBBLE;
            exe_q     <= BUBBLE;
            mem_q     <= BUBBLE;
            wb_q      <= BUBBLE;
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else if (MEM_WAIT) begin
            dec_q <= dec_q;
        end else if (CLEAR) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= BUBBLE;
            dec_q <= BUBBLE;
            if (FLUSH_CNT != '1)
                FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
        end else if (hazard) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= BUBBLE;
            if (STALL_CNT != '1)
                STALL_CNT <= STALL_CNT + CNT_ONE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= dec_q;
            dec_q <= if_stage;
        end
    end

    assign DEC_IR = dec_q.ir;
    assign EXE_IR = exe_q.ir;
    assign MEM_IR = mem_q.ir;
    assign WB_IR  = wb_q.ir;
    assign DEC_PC = dec_q.pc;
    assign EXE_PC = exe_q.pc;
    assign MEM_PC = mem_q.pc;
    assign WB_PC  = wb_q.pc;
    assign DEC_V  = dec_q.v;
    assign EXE_V  = exe_q.v;
    assign MEM_V  = mem_q.v;
    assign WB_V   = wb_q.v;

endmodule

// File: tb/tb_otter_ir_pipeline.sv
// Directed bench for otter_ir_pipeline; a second narrow-counter instance shares
// the stimulus so counter saturation is reached in a few dozen cycles.
module tb_otter_ir_pipeline;

    localparam logic [31:0] NOP_W   = 32'h00000013;
    localparam logic [31:0] ADDI    = 32'h00500093;
    localparam logic [31:0] LW_X5   = 32'h00012283;
    localparam logic [31:0] ADD_X5  = 32'h00128333;
    localparam logic [31:0] LUI_X5  = 32'h000012b7;
    localparam logic [31:0] LW_X0   = 32'h00012003;
    localparam logic [31:0] ADD_X0  = 32'h00000333;
    localparam logic [31:0] LW_SELF = 32'h0002a283;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_ir, if_pc;
    logic        if_valid, clear, mem_wait;

    logic [31:0] dec_ir, exe_ir, mem_ir, wb_ir, dec_pc, exe_pc, mem_pc, wb_pc;
    logic        dec_v, exe_v, mem_v, wb_v, stall;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_dec_ir, s_exe_ir, s_mem_ir, s_wb_ir, s_dec_pc, s_exe_pc, s_mem_pc, s_wb_pc;
    logic        s_dec_v, s_exe_v, s_mem_v, s_wb_v, s_stall;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clk = ~clk;

    otter_ir_pipeline dut (
        .CLK(clk), .RST(rst), .IF_IR(if_ir), .IF_PC(if_pc), .IF_VALID(if_valid),
        .CLEAR(clear), .MEM_WAIT(mem_wait),
        .DEC_IR(dec_ir), .EXE_IR(exe_ir), .MEM_IR(mem_ir), .WB_IR(wb_ir),
        .DEC_PC(dec_pc), .EXE_PC(exe_pc), .MEM_PC(mem_pc), .WB_PC(wb_pc),
        .DEC_V(dec_v), .EXE_V(exe_v), .MEM_V(mem_v), .WB_V(wb_v),
        .STALL(stall), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    otter_ir_pipeline #(.CNT_W(4)) dut_sat (
        .CLK(clk), .RST(rst), .IF_IR(if_ir), .IF_PC(if_pc), .IF_VALID(if_valid),
        .CLEAR(clear), .MEM_WAIT(mem_wait),
        .DEC_IR(s_dec_ir), .EXE_IR(s_exe_ir), .MEM_IR(s_mem_ir), .WB_IR(s_wb_ir),
        .DEC_PC(s_dec_pc), .EXE_PC(s_exe_pc), .MEM_PC(s_mem_pc), .WB_PC(s_wb_pc),
        .DEC_V(s_dec_v), .EXE_V(s_exe_v), .MEM_V(s_mem_v), .WB_V(s_wb_v),
        .STALL(s_stall), .STALL_CNT(s_stall_cnt), .FLUSH_CNT(s_flush_cnt)
    );

    // Drives every DUT input and lets combinational outputs settle.
    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] pc, input logic valid,
                                 input logic clr, input logic mw, input logic rs);
        if_ir    = ir;
        if_pc    = pc;
        if_valid = valid;
        clear    = clr;
        mem_wait = mw;
        rst      = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(NOP_W, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(NOP_W, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_dec_ir", dec_ir, NOP_W);
        checkOutput("rst_wb_ir", wb_ir, NOP_W);
        checkOutput("rst_wb_pc", wb_pc, 0);
        checkOutput("rst_wb_v", {31'd0, wb_v}, 0);
        checkOutput("rst_stall_cnt", {16'd0, stall_cnt}, 0);
        checkOutput("rst_flush_cnt", {16'd0, flush_cnt}, 0);

        // Straight-line flow: four addi words, WB sees the first after the 4th edge.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ADDI, 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("flow_stall", {31'd0, stall}, 0);
            tick();
        end
        checkOutput("flow_wb_ir", wb_ir, ADDI);
        checkOutput("flow_wb_pc", wb_pc, 0);
        checkOutput("flow_wb_v", {31'd0, wb_v}, 1);
        checkOutput("flow_dec_pc", dec_pc, 12);

        // Load-use: lw x5 followed by add reading x5.
        applyStimulus(LW_X5, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD_X5, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADDI, 24, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_stall", {31'd0, stall}, 1);
        tick();
        checkOutput("lu_exe_ir", exe_ir, NOP_W);
        checkOutput("lu_exe_v", {31'd0, exe_v}, 0);
        checkOutput("lu_dec_ir", dec_ir, ADD_X5);
        checkOutput("lu_mem_ir", mem_ir, LW_X5);
        checkOutput("lu_stall_cnt", {16'd0, stall_cnt}, 1);
        checkOutput("lu_stall_after", {31'd0, stall}, 0);
        tick();
        checkOutput("lu_exe_adv", exe_ir, ADD_X5);
        checkOutput("lu_dec_adv", dec_pc, 24);

        // lui does not read registers, so no stall.
        applyStimulus(LW_X5, 28, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(LUI_X5, 32, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADDI, 36, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lui_stall", {31'd0, stall}, 0);
        tick();
        checkOutput("lui_exe_ir", exe_ir, LUI_X5);
        checkOutput("lui_dec_pc", dec_pc, 36);
        checkOutput("lui_stall_cnt", {16'd0, stall_cnt}, 1);

        // Load into x0 never creates a dependency.
        applyStimulus(LW_X0, 40, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD_X0, 44, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("x0_stall", {31'd0, stall}, 0);
        tick();
        checkOutput("x0_exe_ir", exe_ir, ADD_X0);

        // CLEAR overrides a pending hazard.
        applyStimulus(LW_X5, 48, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD_X5, 52, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("clr_hazard_stall", {31'd0, stall}, 1);
        applyStimulus(ADDI, 56, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_stall_masked", {31'd0, stall}, 0);
        tick();
        applyStimulus(LW_X5, 56, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_dec_v", {31'd0, dec_v}, 0);
        checkOutput("clr_exe_v", {31'd0, exe_v}, 0);
        checkOutput("clr_mem_ir", mem_ir, LW_X5);
        checkOutput("clr_mem_pc", mem_pc, 48);
        checkOutput("clr_flush_cnt", {16'd0, flush_cnt}, 1);
        checkOutput("clr_stall_cnt", {16'd0, stall_cnt}, 1);

        // MEM_WAIT freezes everything even with CLEAR and a hazard present.
        tick();
        applyStimulus(ADD_X5, 60, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADDI, 64, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("mw_stall", {31'd0, stall}, 0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("mw_exe_ir", exe_ir, LW_X5);
        checkOutput("mw_exe_pc", exe_pc, 56);
        checkOutput("mw_dec_pc", dec_pc, 60);
        checkOutput("mw_mem_v", {31'd0, mem_v}, 0);
        checkOutput("mw_flush_cnt", {16'd0, flush_cnt}, 1);
        checkOutput("mw_stall_cnt", {16'd0, stall_cnt}, 1);
        applyStimulus(ADDI, 64, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(LW_SELF, 64, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mwr_mem_pc", mem_pc, 56);
        checkOutput("mwr_dec_v", {31'd0, dec_v}, 0);
        checkOutput("mwr_exe_v", {31'd0, exe_v}, 0);
        checkOutput("mwr_flush_cnt", {16'd0, flush_cnt}, 2);
        checkOutput("mwr_stall_cnt", {16'd0, stall_cnt}, 1);

        // Self-dependent loads stall every other cycle: 21 stalls in total.
        tick();
        applyStimulus(LW_SELF, 68, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(LW_SELF, 32'(72 + i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("sat_stall_on", {31'd0, stall}, 1);
            tick();
            checkOutput("sat_stall_off", {31'd0, stall}, 0);
            tick();
        end
        checkOutput("sat_stall_cnt16", {16'd0, stall_cnt}, 21);
        checkOutput("sat_stall_cnt4", {28'd0, s_stall_cnt}, 32'hF);
        checkOutput("sat_flush_cnt4", {28'd0, s_flush_cnt}, 2);

        // Reset wins over a pending stall and a simultaneous CLEAR.
        checkOutput("rst_pre_stall", {31'd0, stall}, 1);
        applyStimulus(LW_SELF, 200, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(LW_X5, 204, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_dec_ir", dec_ir, NOP_W);
        checkOutput("rst2_exe_ir", exe_ir, NOP_W);
        checkOutput("rst2_mem_pc", mem_pc, 0);
        checkOutput("rst2_wb_v", {31'd0, wb_v}, 0);
        checkOutput("rst2_stall_cnt", {16'd0, stall_cnt}, 0);
        checkOutput("rst2_flush_cnt", {16'd0, flush_cnt}, 0);
        checkOutput("rst2_stall", {31'd0, stall}, 0);

        // IF_VALID=0 loads a bubble regardless of IF_IR.
        tick();
        checkOutput("inv_dec_ir", dec_ir, NOP_W);
        checkOutput("inv_dec_pc", dec_pc, 0);
        checkOutput("inv_dec_v", {31'd0, dec_v}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/otter_ir_pipeline.md
Name: otter_ir_pipeline

Overview:
- Instruction-register pipeline for the 5-stage OTTER core. Holds the instruction and PC registers for the DEC, EXE, MEM and WB stages.
- Supplies the IR words consumed by the per-stage decoders.
- Applies the execute-stage CLEAR (taken branch or jump) as a flush, detects load-use hazards and stalls fetch, and freezes on memory wait.
- Keeps saturating stall and flush performance counters.

Parameters:
- XLEN, 32, instruction and PC width.
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_IR  in  XLEN  instruction from the fetch stage.
- IF_PC  in  XLEN  PC of IF_IR.
- IF_VALID  in  1  IF_IR is a real instruction.
- CLEAR  in  1  taken branch or jump resolved in EXE this cycle.
- MEM_WAIT  in  1  data memory not ready; freeze the whole pipeline.
- DEC_IR, EXE_IR, MEM_IR, WB_IR  out  XLEN  stage instruction registers.
- DEC_PC, EXE_PC, MEM_PC, WB_PC  out  XLEN  stage PC registers.
- DEC_V, EXE_V, MEM_V, WB_V  out  1  stage valid bits.
- STALL  out  1  combinational; fetch must hold its PC and IF_IR this cycle.
- STALL_CNT  out  CNT_W  load-use stall cycles counted.
- FLUSH_CNT  out  CNT_W  CLEAR events counted.

Behaviour:
- Reset (RST=1 at an edge):
  - Every xx_IR becomes NOP = 32'h00000013 (addi x0,x0,0).
  - Every xx_PC, xx_V and both counters become 0.
  - RST has priority over every other input, including mid-stall and mid-flush.
- Bubble: IR=NOP, PC=0, V=0.
- Hazard condition, evaluated combinationally on the current DEC/EXE registers:
  - EXE_V=1, EXE opcode is LOAD, and EXE rd (IR[11:7]) is non-zero.
  - DEC_V=1, and DEC uses rs1 (IR[19:15]) or rs2 (IR[24:20]) equal to EXE rd.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and SYSTEM with func3[2]=0.
- rs2 is used by BRANCH, STORE, OP. LUI, AUIPC and JAL use neither.
- STALL = hazard & ~CLEAR & ~MEM_WAIT.
- Per-edge update, first matching rule applies:
  1. MEM_WAIT=1: all stage registers and counters hold; STALL=0. Fetch holds because of MEM_WAIT itself.
  2. CLEAR=1:
     - WB<=MEM and MEM<=EXE.
     - EXE<=bubble (squashes DEC) and DEC<=bubble (squashes IF).
     - FLUSH_CNT increments.
     - CLEAR overrides any hazard; the squashed instructions do not stall.
  3. Hazard:
     - WB<=MEM, MEM<=EXE, EXE<=bubble; DEC holds.
     - STALL_CNT increments.
  4. Otherwise: WB<=MEM, MEM<=EXE, EXE<=DEC, DEC<={IF_IR, IF_PC, IF_VALID}.
- Latency: an instruction accepted into DEC reaches WB 3 edges later when there are no stalls.
- A load-use stall lasts exactly 1 cycle. After the bubble, EXE holds a non-load, so the hazard deasserts.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- CLEAR while EXE_V=0 is a protocol error. It is still honoured as a flush.
- IF_VALID=0 loads a bubble into DEC. IF_IR is then ignored and DEC_IR=NOP.

Decomposition:
- Shared package otter_pkg:
  - opcode_t enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM.
  - NOP constant.
  - uses_rs1 and uses_rs2 functions.
  - The stage decoders use the same package.
- One combinational sub-module, otter_hazard_detect:
  - Inputs: DEC_IR, DEC_V, EXE_IR, EXE_V.
  - Output: hazard.
  - Must be instantiable by the forwarding unit.
- A stage-register struct {ir, pc, v} in otter_pkg keeps the shift logic uniform.

Test Plan:
- Reset then 4 edges of IF_IR=32'h00500093 (addi x1,x0,5), PCs 0,4,8,12, IF_VALID=1 -> WB_IR=32'h00500093, WB_PC=0, WB_V=1 after the 4th edge; STALL never asserted.
- EXE holds lw x5,0(x2) (32'h00012283) and DEC holds add x6,x5,x1 (32'h00128333) -> STALL=1 that cycle. Next edge: EXE=NOP with EXE_V=0, DEC unchanged, MEM=lw, STALL_CNT=1. The following edge advances the add to EXE.
- Same load in EXE, DEC holds lui x5,1 (32'h000012b7) -> STALL=0 (rs not used); normal advance.
- Load with rd=x0 in EXE, DEC reads x0 -> no stall.
- CLEAR=1 with a hazard also present -> next edge DEC_V=0, EXE_V=0, MEM holds the former EXE instruction, FLUSH_CNT=1, STALL_CNT unchanged, STALL=0.
- MEM_WAIT=1 for 3 cycles with CLEAR=1 and a hazard present -> all registers and counters frozen. On release, the flush applies once and FLUSH_CNT increments by 1. Preload STALL_CNT to 16'hFFFF via repeated hazards and confirm it saturates at 16'hFFFF. RST asserted mid-stall -> all regs NOP/0 on the next edge.
